// File: rtl/seat_grid_controller.sv
// Seat-grid overlay controller: keeps a ROWS x COLS occupancy map and a blinking
// cursor, and paints the seats over a video background stream.
// Ports:
//   clk, rst            - sole clock, synchronous active-low reset
//   bright, hCount,
//   vCount, background  - current pixel position, visibility and underlying colour
//   btn_up/down/left/
//   btn_right           - single-cycle cursor move pulses (priority up>down>left>right)
//   btn_sel             - single-cycle toggle of the seat under the cursor
//   clr_all             - single-cycle clear of every seat
//   rgb                 - registered pixel colour, one clock after the pixel inputs
//   cursor_row/col      - current cursor position
//   occ_count           - number of occupied seats
module seat_grid_controller #(
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SEAT_W       = 35,
  parameter int unsigned SEAT_H       = 35,
  parameter int unsigned SPACING      = 15,
  parameter int unsigned BASE_X       = 365,
  parameter int unsigned BASE_Y       = 315,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned WRAP         = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [11:0] background,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        clr_all,
  output logic [11:0] rgb,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic [6:0]  occ_count
);

  localparam int unsigned NSEAT   = ROWS * COLS;
  localparam int unsigned PITCH_X = SEAT_W + SPACING;
  localparam int unsigned PITCH_Y = SEAT_H + SPACING;
  localparam int unsigned CW      = 16;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RGB_W-1:0] C_OFF    = 12'h000;
  localparam logic [RGB_W-1:0] C_CURSOR = 12'hFF0;
  localparam logic [RGB_W-1:0] C_OCC    = 12'hF00;
  localparam logic [RGB_W-1:0] C_EMPTY  = 12'h840;

  // State registers
  logic [NSEAT-1:0] occ;
  logic             blink;
  logic [FC_W-1:0]  frame_cnt;

  // Next-state values
  logic [NSEAT-1:0] occ_n;
  logic             blink_n;
  logic [FC_W-1:0]  frame_cnt_n;
  logic [POS_W-1:0] row_n;
  logic [POS_W-1:0] col_n;
  logic [CNT_W-1:0] occ_count_n;
  logic [RGB_W-1:0] rgb_n;

  // Pixel decode results
  logic [CW-1:0]    h_ext;
  logic [CW-1:0]    v_ext;
  logic             row_hit;
  logic             col_hit;
  logic [POS_W-1:0] row_idx;
  logic [POS_W-1:0] col_idx;
  logic             pix_occ;
  logic             pix_cursor;

  // Cursor-side helpers
  logic             move;
  logic             sel_was;
  logic             tick;

  assign h_ext = CW'(hCount);
  assign v_ext = CW'(vCount);
  assign move  = btn_up | btn_down | btn_left | btn_right;
  assign tick  = (hCount == 10'd0) && (vCount == 10'd0);

  // Map the pixel onto a seat row/column band; bands never overlap.
  always_comb begin
    row_hit = 1'b0;
    col_hit = 1'b0;
    row_idx = '0;
    col_idx = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (v_ext >= CW'(BASE_Y + r * PITCH_Y) &&
          v_ext <= CW'(BASE_Y + r * PITCH_Y + SEAT_H - 1)) begin
        row_hit = 1'b1;
        row_idx = POS_W'(r);
      end
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (h_ext >= CW'(BASE_X + c * PITCH_X) &&
          h_ext <= CW'(BASE_X + c * PITCH_X + SEAT_W - 1)) begin
        col_hit = 1'b1;
        col_idx = POS_W'(c);
      end
    end
  end

  // Occupancy of the pixel's seat and of the cursor's seat.
  always_comb begin
    pix_occ = 1'b0;
    sel_was = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (row_idx == POS_W'(r) && col_idx == POS_W'(c)) pix_occ = occ[r*COLS + c];
        if (cursor_row == POS_W'(r) && cursor_col == POS_W'(c)) sel_was = occ[r*COLS + c];
      end
    end
    pix_cursor = row_hit && col_hit && (row_idx == cursor_row) && (col_idx == cursor_col);
  end

  // Next-state: cursor, occupancy, blink and pixel colour.
  always_comb begin
    row_n       = cursor_row;
    col_n       = cursor_col;
    occ_n       = occ;
    occ_count_n = occ_count;
    blink_n     = blink;
    frame_cnt_n = frame_cnt;
    rgb_n       = background;

    // Single move per cycle, highest-priority pulse wins.
    if (btn_up) begin
      if (cursor_row != 3'd0)  row_n = cursor_row - 3'd1;
      else if (WRAP != 0)      row_n = POS_W'(ROWS - 1);
    end else if (btn_down) begin
      if (cursor_row != POS_W'(ROWS - 1)) row_n = cursor_row + 3'd1;
      else if (WRAP != 0)                 row_n = '0;
    end else if (btn_left) begin
      if (cursor_col != 3'd0)  col_n = cursor_col - 3'd1;
      else if (WRAP != 0)      col_n = POS_W'(COLS - 1);
    end else if (btn_right) begin
      if (cursor_col != POS_W'(COLS - 1)) col_n = cursor_col + 3'd1;
      else if (WRAP != 0)                 col_n = '0;
    end

    // Toggle acts on the pre-move seat; clear-all overrides it.
    if (clr_all) begin
      occ_n       = '0;
      occ_count_n = '0;
    end else if (btn_sel) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (cursor_row == POS_W'(r) && cursor_col == POS_W'(c))
            occ_n[r*COLS + c] = ~occ[r*COLS + c];
        end
      end
      occ_count_n = sel_was ? (occ_count - 7'd1) : (occ_count + 7'd1);
    end

    // Blink phase flips every BLINK_FRAMES frames; any user action restarts it visible.
    if (tick) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_n = '0;
        blink_n     = ~blink;
      end else begin
        frame_cnt_n = frame_cnt + FC_W'(1);
      end
    end
    if (move || btn_sel) begin
      blink_n     = 1'b1;
      frame_cnt_n = '0;
    end

    // Colour priority
    if (!bright)                    rgb_n = C_OFF;
    else if (pix_cursor && blink)   rgb_n = C_CURSOR;
    else if (row_hit && col_hit)    rgb_n = pix_occ ? C_OCC : C_EMPTY;
    else                            rgb_n = background;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      blink      <= 1'b1;
      frame_cnt  <= '0;
      rgb        <= C_OFF;
      occ_count  <= '0;
    end else begin
      occ        <= occ_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      blink      <= blink_n;
      frame_cnt  <= frame_cnt_n;
      rgb        <= rgb_n;
      occ_count  <= occ_count_n;
    end
  end

endmodule

// File: tb/tb_seat_grid_controller.sv
// Directed bench for seat_grid_controller: a saturating and a wrapping instance
// share stimulus; expectations are queued with a due cycle and checked by a monitor.
module tb_seat_grid_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [11:0] background;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel, clr_all;
  logic [11:0] rgb, rgb_w;
  logic [2:0]  cursor_row, cursor_col, cursor_row_w, cursor_col_w;
  logic [6:0]  occ_count, occ_count_w;

  localparam logic [11:0] BG = 12'h5A5;

  always #5 clk = ~clk;

  seat_grid_controller #(.WRAP(0)) dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .background(background), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .clr_all(clr_all),
    .rgb(rgb), .cursor_row(cursor_row), .cursor_col(cursor_col), .occ_count(occ_count)
  );

  seat_grid_controller #(.WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .background(background), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .clr_all(clr_all),
    .rgb(rgb_w), .cursor_row(cursor_row_w), .cursor_col(cursor_col_w),
    .occ_count(occ_count_w)
  );

  // Observable selectors
  localparam int K_RGB = 0, K_ROW = 1, K_COL = 2, K_OCC = 3;
  localparam int K_RGB_W = 4, K_ROW_W = 5, K_COL_W = 6, K_OCC_W = 7;

  typedef struct {
    string       name;
    int unsigned due;
    int          kind;
    logic [11:0] exp;
  } exp_t;

  exp_t        q[$];
  int unsigned k      = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [11:0] actual(input int kind);
    case (kind)
      K_RGB:   return rgb;
      K_ROW:   return 12'(cursor_row);
      K_COL:   return 12'(cursor_col);
      K_OCC:   return 12'(occ_count);
      K_RGB_W: return rgb_w;
      K_ROW_W: return 12'(cursor_row_w);
      K_COL_W: return 12'(cursor_col_w);
      default: return 12'(occ_count_w);
    endcase
  endfunction

  // Expectation due right after the next active edge.
  task automatic expect_v(input string name, input int kind, input logic [11:0] v);
    exp_t e;
    e.name = name;
    e.due  = k + 1;
    e.kind = kind;
    e.exp  = v;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation whose edge has passed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      k++;
      while (q.size() > 0 && q[0].due <= k) begin
        exp_t e;
        logic [11:0] a;
        e = q.pop_front();
        a = actual(e.kind);
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.exp, k);
        end
      end
    end
  end

  task automatic idle();
    bright    = 1'b0;
    hCount    = 10'd1;
    vCount    = 10'd0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_sel   = 1'b0;
    clr_all   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    expect_v("rst_rgb", K_RGB, 12'h000);
    expect_v("rst_occ", K_OCC, 12'd0);
    expect_v("rst_row", K_ROW, 12'd0);
    expect_v("rst_col", K_COL, 12'd0);
    step();
    rst = 1'b1;
  endtask

  task automatic px(input string name, input int h, input int v, input logic [11:0] exp);
    bright = 1'b1;
    hCount = 10'(h);
    vCount = 10'(v);
    expect_v(name, K_RGB, exp);
    step();
  endtask

  task automatic ticks(input int n);
    hCount = 10'd0;
    vCount = 10'd0;
    repeat (n) @(negedge clk);
    idle();
  endtask

  initial begin
    rst        = 1'b0;
    background = BG;
    idle();
    repeat (2) @(negedge clk);

    // Reset values, cursor highlight and seat boundaries
    do_reset();
    px("cur_origin", 365, 315, 12'hFF0);
    px("cur_right_edge", 399, 349, 12'hFF0);
    px("gap_right", 400, 315, BG);
    px("gap_below", 365, 350, BG);

    // Right moves: saturate vs wrap
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      btn_right = 1'b1;
      expect_v($sformatf("sat_col_%0d", i), K_COL, 12'((i > 3) ? 3 : i));
      expect_v($sformatf("wrap_col_%0d", i), K_COL_W, 12'(i % 4));
      step();
    end

    // Simultaneous moves: up wins; at the top edge it holds or wraps
    do_reset();
    btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    expect_v("prio_row", K_ROW, 12'd0);
    expect_v("prio_col", K_COL, 12'd0);
    expect_v("prio_row_w", K_ROW_W, 12'd1);
    expect_v("prio_col_w", K_COL_W, 12'd0);
    step();

    // Occupy (1,2), then watch its colour across the blink phase change
    do_reset();
    btn_down = 1'b1; step();
    btn_right = 1'b1; step();
    btn_right = 1'b1;
    expect_v("cur_row_1", K_ROW, 12'd1);
    expect_v("cur_col_2", K_COL, 12'd2);
    step();
    btn_sel = 1'b1;
    expect_v("sel_occ1", K_OCC, 12'd1);
    step();
    px("sel_cursor_on", 465, 365, 12'hFF0);
    px("empty_00", 365, 315, 12'h840);
    px("gap_464", 464, 365, BG);
    ticks(15);
    px("blink_still_on", 465, 365, 12'hFF0);
    ticks(1);
    px("blink_off_occ", 465, 365, 12'hF00);
    px("occ_far_corner", 499, 399, 12'hF00);
    px("gap_500", 500, 365, BG);

    // Select with a move: toggles the pre-move seat
    do_reset();
    btn_sel = 1'b1; btn_down = 1'b1;
    expect_v("selmv_occ", K_OCC, 12'd1);
    expect_v("selmv_row", K_ROW, 12'd1);
    expect_v("selmv_col", K_COL, 12'd0);
    step();
    px("selmv_seat00", 365, 315, 12'hF00);

    // Three seats, then clear-all overriding select
    btn_sel = 1'b1;
    expect_v("occ2", K_OCC, 12'd2);
    step();
    btn_right = 1'b1; step();
    btn_sel = 1'b1;
    expect_v("occ3", K_OCC, 12'd3);
    step();
    px("occ3_cursor", 415, 365, 12'hFF0);
    clr_all = 1'b1; btn_sel = 1'b1;
    expect_v("clr_occ", K_OCC, 12'd0);
    step();
    ticks(16);
    px("clr_s00", 365, 315, 12'h840);
    px("clr_s10", 365, 365, 12'h840);
    px("clr_s11", 415, 365, 12'h840);
    px("clr_s03", 515, 315, 12'h840);

    // Five seats via select-with-move, then mid-frame reset
    btn_sel = 1'b1; btn_left = 1'b1; step();
    btn_sel = 1'b1; btn_up = 1'b1; step();
    btn_sel = 1'b1; btn_right = 1'b1; step();
    btn_sel = 1'b1; btn_right = 1'b1; step();
    btn_sel = 1'b1;
    expect_v("occ5", K_OCC, 12'd5);
    expect_v("occ5_row", K_ROW, 12'd0);
    expect_v("occ5_col", K_COL, 12'd2);
    step();
    rst = 1'b0; bright = 1'b1; hCount = 10'd465; vCount = 10'd315;
    btn_sel = 1'b1; btn_right = 1'b1;
    expect_v("midrst_rgb", K_RGB, 12'h000);
    expect_v("midrst_occ", K_OCC, 12'd0);
    expect_v("midrst_row", K_ROW, 12'd0);
    expect_v("midrst_col", K_COL, 12'd0);
    expect_v("midrst_occ_w", K_OCC_W, 12'd0);
    step();
    rst = 1'b1;
    hCount = 10'd365; vCount = 10'd315;
    expect_v("dark_rgb", K_RGB, 12'h000);
    step();
    px("post_rst_cursor", 365, 315, 12'hFF0);
    px("post_rst_s01", 415, 315, 12'h840);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
